// File: rtl/song_rom_player.sv
// Multi-song note sequencer: programmable per-song note/duration tables played back
// with start/pause/stop/loop transport control, one note word at a time.
module song_rom_player #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned DUR_WIDTH  = 3,
   parameter int unsigned NUM_SONGS  = 4,
   parameter int unsigned MAX_NOTES  = 64,
   parameter int unsigned TICK_DIV   = 50000000,
   localparam int unsigned SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
   localparam int unsigned ADDR_W    = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1,
   localparam int unsigned LEN_W     = ADDR_W + 1,
   localparam int unsigned ENTRY_W   = DUR_WIDTH + DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEL_W-1:0]      song_sel,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  stop,
   input  logic                  loop_en,
   input  logic                  wr_en,
   input  logic [SEL_W-1:0]      wr_song,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [ENTRY_W-1:0]    wr_data,
   input  logic                  len_we,
   input  logic [LEN_W-1:0]      len_data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  note_valid,
   output logic                  note_strobe,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     position
);

   localparam int unsigned MEM_N  = NUM_SONGS * MAX_NOTES;
   localparam int unsigned MEM_AW = (MEM_N > 1) ? $clog2(MEM_N) : 1;
   localparam longint unsigned CNT_MAX = ((64'd1 << DUR_WIDTH) - 64'd1) * 64'(TICK_DIV);
   localparam int unsigned CNT_W  = $clog2(CNT_MAX + 64'd1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_PAUSED} state_e;

   logic [ENTRY_W-1:0] mem [MEM_N];
   logic [ENTRY_W-1:0] rd_data_q;
   logic [LEN_W-1:0]   len_q [NUM_SONGS];

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    song_q, song_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                fetch_rdy_q, fetch_rdy_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                strobe_q, strobe_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [LEN_W-1:0]     cur_len;
   logic [LEN_W-1:0]     ptr_inc;
   logic                 wrap;
   logic [ADDR_W-1:0]    rd_addr;
   logic [DUR_WIDTH-1:0] rd_dur;
   logic [DATA_WIDTH-1:0] rd_note;
   logic [CNT_W-1:0]     load_cnt;

   // During PLAY/PAUSED the read port always holds the next entry, so expiry never stalls
   always_comb begin
      cur_len  = len_q[song_q];
      ptr_inc  = LEN_W'(ptr_q) + LEN_W'(1);
      wrap     = (ptr_inc >= cur_len);
      rd_addr  = ptr_q;
      if (state_q == S_PLAY || state_q == S_PAUSED) begin
         rd_addr = wrap ? '0 : ptr_inc[ADDR_W-1:0];
      end
      rd_dur   = rd_data_q[ENTRY_W-1:DATA_WIDTH];
      rd_note  = rd_data_q[DATA_WIDTH-1:0];
      load_cnt = CNT_W'((rd_dur == '0) ? DUR_WIDTH'(1) : rd_dur) * CNT_W'(TICK_DIV);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[MEM_AW'(wr_song) * MEM_AW'(MAX_NOTES) + MEM_AW'(wr_addr)] <= wr_data;
      end
      rd_data_q <= mem[MEM_AW'(song_q) * MEM_AW'(MAX_NOTES) + MEM_AW'(rd_addr)];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_SONGS); i++) len_q[i] <= '0;
      end else if (len_we) begin
         len_q[wr_song] <= (len_data > LEN_W'(MAX_NOTES)) ? LEN_W'(MAX_NOTES) : len_data;
      end
   end

   always_comb begin
      logic run;
      state_d     = state_q;
      song_d      = song_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      fetch_rdy_d = 1'b0;
      data_d      = data_q;
      valid_d     = valid_q;
      strobe_d    = 1'b0;
      done_d      = 1'b0;
      run         = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
         ptr_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  song_d = song_sel;
                  if (len_q[song_sel] == '0) begin
                     done_d = 1'b1;
                  end else begin
                     ptr_d   = '0;
                     state_d = S_FETCH;
                  end
               end
            end
            // First cycle issues the read, second cycle consumes it
            S_FETCH: begin
               fetch_rdy_d = 1'b1;
               if (fetch_rdy_q) begin
                  fetch_rdy_d = 1'b0;
                  data_d      = rd_note;
                  valid_d     = 1'b1;
                  strobe_d    = 1'b1;
                  cnt_d       = load_cnt;
                  state_d     = S_PLAY;
               end
            end
            S_PLAY: begin
               if (pause) begin
                  state_d = S_PAUSED;
                  valid_d = 1'b0;
               end else begin
                  run = 1'b1;
               end
            end
            S_PAUSED: begin
               if (!pause) begin
                  state_d = S_PLAY;
                  valid_d = 1'b1;
                  run     = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase

         if (run) begin
            if (cnt_q > CNT_W'(1)) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!wrap || loop_en) begin
               ptr_d    = wrap ? '0 : ptr_inc[ADDR_W-1:0];
               data_d   = rd_note;
               valid_d  = 1'b1;
               strobe_d = 1'b1;
               cnt_d    = load_cnt;
            end else begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               done_d  = 1'b1;
            end
         end
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         song_q      <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         fetch_rdy_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         song_q      <= song_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         fetch_rdy_q <= fetch_rdy_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         strobe_q    <= strobe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign data_out    = data_q;
   assign note_valid  = valid_q;
   assign note_strobe = strobe_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign position    = ptr_q;

endmodule

// File: tb/tb_song_rom_player.sv
// Directed bench for song_rom_player with TICK_DIV=4: play, loop, pause, stop,
// empty song, start-while-busy and mid-song reset.
module tb_song_rom_player;

   localparam int unsigned DW = 10;
   localparam int unsigned UW = 3;
   localparam int unsigned SW = 2;
   localparam int unsigned AW = 6;
   localparam int unsigned LOGN = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [SW-1:0] song_sel;
   logic          start, pause, stop, loop_en;
   logic          wr_en;
   logic [SW-1:0] wr_song;
   logic [AW-1:0] wr_addr;
   logic [UW+DW-1:0] wr_data;
   logic          len_we;
   logic [AW:0]   len_data;
   logic [DW-1:0] data_out;
   logic          note_valid, note_strobe, busy, done;
   logic [AW-1:0] position;

   song_rom_player #(
      .DATA_WIDTH(DW), .DUR_WIDTH(UW), .NUM_SONGS(4), .MAX_NOTES(64), .TICK_DIV(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .song_sel(song_sel), .start(start), .pause(pause),
      .stop(stop), .loop_en(loop_en), .wr_en(wr_en), .wr_song(wr_song),
      .wr_addr(wr_addr), .wr_data(wr_data), .len_we(len_we), .len_data(len_data),
      .data_out(data_out), .note_valid(note_valid), .note_strobe(note_strobe),
      .busy(busy), .done(done), .position(position)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic          str_l  [LOGN];
   logic          done_l [LOGN];
   logic          val_l  [LOGN];
   logic          busy_l [LOGN];
   logic [DW-1:0] dat_l  [LOGN];
   logic [AW-1:0] pos_l  [LOGN];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic log_cyc();
      if (cyc < int'(LOGN)) begin
         str_l[cyc]  = note_strobe;
         done_l[cyc] = done;
         val_l[cyc]  = note_valid;
         busy_l[cyc] = busy;
         dat_l[cyc]  = data_out;
         pos_l[cyc]  = position;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         cyc++;
         log_cyc();
      end
   endtask

   // Pulse start for one edge; cycle 0 is the sample just after that edge
   task automatic go(input logic [SW-1:0] s);
      for (int i = 0; i < int'(LOGN); i++) begin
         str_l[i] = 1'b0; done_l[i] = 1'b0; val_l[i] = 1'b0;
         busy_l[i] = 1'b0; dat_l[i] = '0; pos_l[i] = '0;
      end
      song_sel = s;
      start    = 1'b1;
      step();
      start = 1'b0;
      cyc   = 0;
      log_cyc();
   endtask

   task automatic prog(input logic [SW-1:0] s, input logic [AW-1:0] a,
                       input logic [UW-1:0] d, input logic [DW-1:0] n);
      wr_song = s; wr_addr = a; wr_data = {d, n}; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
   endtask

   task automatic set_len(input logic [SW-1:0] s, input logic [AW:0] l);
      wr_song = s; len_data = l; len_we = 1'b1;
      step();
      len_we = 1'b0;
   endtask

   function automatic int cnt_str(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (str_l[i]) n++;
      return n;
   endfunction

   function automatic int cnt_done(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (done_l[i]) n++;
      return n;
   endfunction

   function automatic int cnt_silent(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (!val_l[i]) n++;
      return n;
   endfunction

   initial begin
      rst_n = 1'b0; song_sel = '0; start = 1'b0; pause = 1'b0; stop = 1'b0;
      loop_en = 1'b0; wr_en = 1'b0; wr_song = '0; wr_addr = '0; wr_data = '0;
      len_we = 1'b0; len_data = '0;
      step(); step();
      rst_n = 1'b1;
      step();

      chk("rst_data",   32'(data_out), 32'h0);
      chk("rst_valid",  32'(note_valid), 32'h0);
      chk("rst_strobe", 32'(note_strobe), 32'h0);
      chk("rst_busy",   32'(busy), 32'h0);
      chk("rst_done",   32'(done), 32'h0);
      chk("rst_pos",    32'(position), 32'h0);

      prog(2'd1, 6'd0, 3'd1, 10'h004);
      prog(2'd1, 6'd1, 3'd2, 10'h040);
      prog(2'd1, 6'd2, 3'd3, 10'h080);
      set_len(2'd1, 7'd3);

      // Basic playback: strobes at +2/+6/+14, done at +26
      go(2'd1);
      chk("t1_busy0",  32'(busy), 32'h1);
      chk("t1_valid0", 32'(note_valid), 32'h0);
      run(30);
      chk("t1_nstr",   32'(cnt_str(0, 30)), 32'd3);
      chk("t1_str2",   32'(str_l[2]), 32'h1);
      chk("t1_dat2",   32'(dat_l[2]), 32'h004);
      chk("t1_val2",   32'(val_l[2]), 32'h1);
      chk("t1_str6",   32'(str_l[6]), 32'h1);
      chk("t1_dat6",   32'(dat_l[6]), 32'h040);
      chk("t1_pos6",   32'(pos_l[6]), 32'h1);
      chk("t1_str14",  32'(str_l[14]), 32'h1);
      chk("t1_dat14",  32'(dat_l[14]), 32'h080);
      chk("t1_pos14",  32'(pos_l[14]), 32'h2);
      chk("t1_ndone",  32'(cnt_done(0, 30)), 32'd1);
      chk("t1_done26", 32'(done_l[26]), 32'h1);
      chk("t1_val25",  32'(val_l[25]), 32'h1);
      chk("t1_val26",  32'(val_l[26]), 32'h0);
      chk("t1_busy26", 32'(busy_l[26]), 32'h0);
      chk("t1_busy25", 32'(busy_l[25]), 32'h1);

      // Looping: second pass starts at +26 with no gap, then ends at +50 once loop drops
      loop_en = 1'b1;
      go(2'd1);
      run(40);
      loop_en = 1'b0;
      run(20);
      chk("lp_str26",  32'(str_l[26]), 32'h1);
      chk("lp_dat26",  32'(dat_l[26]), 32'h004);
      chk("lp_pos26",  32'(pos_l[26]), 32'h0);
      chk("lp_val26",  32'(val_l[26]), 32'h1);
      chk("lp_nodone", 32'(cnt_done(0, 49)), 32'd0);
      chk("lp_nstr",   32'(cnt_str(0, 60)), 32'd6);
      chk("lp_done50", 32'(done_l[50]), 32'h1);
      chk("lp_val50",  32'(val_l[50]), 32'h0);

      // Pause 10 cycles during note 2: note 3 slides from +14 to +24
      go(2'd1);
      run(8);
      pause = 1'b1;
      run(10);
      pause = 1'b0;
      run(22);
      chk("pz_silent", 32'(cnt_silent(7, 23)), 32'd10);
      chk("pz_val9",   32'(val_l[9]), 32'h0);
      chk("pz_val19",  32'(val_l[19]), 32'h1);
      chk("pz_dat12",  32'(dat_l[12]), 32'h040);
      chk("pz_nostr",  32'(cnt_str(7, 23)), 32'd0);
      chk("pz_str24",  32'(str_l[24]), 32'h1);
      chk("pz_dat24",  32'(dat_l[24]), 32'h080);
      chk("pz_done36", 32'(done_l[36]), 32'h1);

      // Stop while paused mid-note
      go(2'd1);
      run(8);
      pause = 1'b1;
      run(3);
      chk("st_pos_pre", 32'(position), 32'h1);
      stop = 1'b1;
      run(1);
      stop = 1'b0;
      pause = 1'b0;
      chk("st_busy",  32'(busy), 32'h0);
      chk("st_valid", 32'(note_valid), 32'h0);
      chk("st_pos",   32'(position), 32'h0);
      run(30);
      chk("st_nodone", 32'(cnt_done(0, 42)), 32'd0);
      chk("st_nostr",  32'(cnt_str(12, 42)), 32'd0);

      // Empty song: single done pulse, never busy
      go(2'd2);
      chk("e0_done", 32'(done), 32'h1);
      chk("e0_busy", 32'(busy), 32'h0);
      run(3);
      chk("e0_ndone", 32'(cnt_done(1, 3)), 32'd0);
      chk("e0_busy3", 32'(busy), 32'h0);

      // Start during playback is ignored
      go(2'd1);
      run(4);
      song_sel = 2'd2;
      start = 1'b1;
      run(1);
      start = 1'b0;
      run(25);
      chk("sb_done5",  32'(done_l[5]), 32'h0);
      chk("sb_dat6",   32'(dat_l[6]), 32'h040);
      chk("sb_done26", 32'(done_l[26]), 32'h1);
      chk("sb_ndone",  32'(cnt_done(0, 30)), 32'd1);

      // Asynchronous reset mid-song, then lengths are gone
      go(2'd1);
      run(8);
      chk("rm_pre_dat", 32'(data_out), 32'h040);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rm_data",  32'(data_out), 32'h0);
      chk("rm_valid", 32'(note_valid), 32'h0);
      chk("rm_busy",  32'(busy), 32'h0);
      chk("rm_pos",   32'(position), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      go(2'd1);
      chk("rm_done", 32'(done), 32'h1);
      chk("rm_busy2", 32'(busy), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
